// File: rtl/i_cache.sv
// Direct-mapped, read-only instruction cache feeding the IF stage.
// Misses refill a whole line by burst read; kseg1 fetches bypass the arrays as single-word reads.
module i_cache #(
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        inst_enF,
    input  logic        cpu_stall,
    output logic [31:0] instrF,
    output logic        i_cache_stall,
    output logic        i_cache_hit,
    output logic        mem_rreq,
    output logic [31:0] mem_raddr,
    output logic [1:0]  mem_rlen,
    input  logic        mem_addr_ok,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rlast
);
    localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int LINES      = 1 << INDEX_WIDTH;
    localparam int WORD_WIDTH = OFFSET_WIDTH - 2;
    localparam int WORDS      = 1 << WORD_WIDTH;
    localparam logic [1:0] LINE_RLEN = 2'(WORDS - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] MISS_REQ = 3'd1;
    localparam logic [2:0] REFILL   = 3'd2;
    localparam logic [2:0] UC_REQ   = 3'd3;
    localparam logic [2:0] UC_WAIT  = 3'd4;
    localparam logic [2:0] UC_DONE  = 3'd5;

    logic [2:0]             state_reg, state_next;
    logic [LINES-1:0]       valid_reg;
    logic [TAG_WIDTH-1:0]   tag_reg [LINES];
    logic [31:0]            data_reg [LINES][WORDS];
    logic [WORD_WIDTH-1:0]  cnt_reg;
    logic [31:0]            uc_buf_reg;
    logic [31:0]            req_addr_reg;
    logic [INDEX_WIDTH-1:0] miss_index_reg;
    logic [TAG_WIDTH-1:0]   miss_tag_reg;

    logic [31:0]            paddr;
    logic                   uncached;
    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   tag;
    logic [WORD_WIDTH-1:0]  word;
    logic                   hit;
    logic                   leave_idle;
    logic                   accept_line;
    logic                   beat;
    logic                   last_beat;

    assign paddr    = {3'b000, pcF[28:0]};
    assign uncached = (pcF[31:29] == 3'b101);
    assign index    = paddr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign tag      = paddr[31 -: TAG_WIDTH];
    assign word     = paddr[2 +: WORD_WIDTH];
    assign hit      = ~uncached & valid_reg[index] & (tag_reg[index] == tag);

    // An uncached fetch never hits, so this covers both the miss and the bypass path.
    assign leave_idle  = (state_reg == IDLE) & inst_enF & ~hit;
    assign accept_line = (state_reg == MISS_REQ) & mem_addr_ok;
    assign beat        = (state_reg == REFILL) & mem_rvalid;
    assign last_beat   = beat & mem_rlast;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (leave_idle) state_next = uncached ? UC_REQ : MISS_REQ;
            MISS_REQ: if (mem_addr_ok) state_next = REFILL;
            REFILL:   if (last_beat) state_next = IDLE;
            UC_REQ:   if (mem_addr_ok) state_next = UC_WAIT;
            UC_WAIT:  if (mem_rvalid) state_next = UC_DONE;
            UC_DONE:  if (!cpu_stall) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            uc_buf_reg     <= '0;
            req_addr_reg   <= '0;
            miss_index_reg <= '0;
            miss_tag_reg   <= '0;
        end else begin
            state_reg <= state_next;
            // Miss address is frozen here so later pcF changes cannot redirect the refill.
            if (leave_idle) begin
                miss_index_reg <= index;
                miss_tag_reg   <= tag;
                req_addr_reg   <= uncached ? paddr
                                           : {paddr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
            end
            if (accept_line) begin
                cnt_reg <= '0;
            end else if (beat) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if ((state_reg == UC_WAIT) && mem_rvalid) begin
                uc_buf_reg <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (accept_line) begin
            valid_reg[miss_index_reg] <= 1'b0;
        end else if (last_beat) begin
            valid_reg[miss_index_reg] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            data_reg[miss_index_reg][cnt_reg] <= mem_rdata;
        end
        if (last_beat) begin
            tag_reg[miss_index_reg] <= miss_tag_reg;
        end
    end

    always_comb begin
        instrF        = '0;
        i_cache_stall = 1'b0;
        i_cache_hit   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (inst_enF) begin
                    if (hit) begin
                        instrF      = data_reg[index][word];
                        i_cache_hit = 1'b1;
                    end else begin
                        i_cache_stall = 1'b1;
                    end
                end
            end
            UC_DONE: instrF = uc_buf_reg;
            default: i_cache_stall = 1'b1;
        endcase
    end

    assign mem_rreq  = (state_reg == MISS_REQ) | (state_reg == UC_REQ);
    assign mem_raddr = mem_rreq ? req_addr_reg : '0;
    assign mem_rlen  = (state_reg == MISS_REQ) ? LINE_RLEN : 2'd0;

endmodule

// File: tb/tb_i_cache.sv
// Randomized bench for i_cache: a bridge responder with random delays plus a line-presence
// model of the cache predict data, hit flag, request fields and exact stall length.
module tb_i_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        inst_enF;
    logic        cpu_stall;
    logic [31:0] instrF;
    logic        i_cache_stall;
    logic        i_cache_hit;
    logic        mem_rreq;
    logic [31:0] mem_raddr;
    logic [1:0]  mem_rlen;
    logic        mem_addr_ok;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rlast;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    i_cache dut (
        .clk(clk), .rst(rst), .pcF(pcF), .inst_enF(inst_enF), .cpu_stall(cpu_stall),
        .instrF(instrF), .i_cache_stall(i_cache_stall), .i_cache_hit(i_cache_hit),
        .mem_rreq(mem_rreq), .mem_raddr(mem_raddr), .mem_rlen(mem_rlen),
        .mem_addr_ok(mem_addr_ok), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_rlast(mem_rlast)
    );

    // Cache model: which line (by physical tag) each index currently holds.
    logic        mvalid [64];
    logic [21:0] mtag   [64];

    // Responder controls and observations.
    int          force_wait = -1;
    int          force_gap  = -1;
    int          max_gap    = 1;
    bit          spurious_en = 1'b1;
    logic [31:0] exp_raddr = '0;
    logic [1:0]  exp_rlen  = '0;
    int          n_req = 0;
    int          beats_done = 0;
    int          last_exp_stall = 0;
    logic [31:0] last_raddr = '0;
    logic [1:0]  last_rlen  = '0;
    bit          mon_en = 1'b0;
    bit          expect_idle = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1FC00000) return 32'h3C080001;
        return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'hA5A50000;
    endfunction

    function automatic logic [31:0] paddr_of(input logic [31:0] pc);
        return {3'b000, pc[28:0]};
    endfunction

    function automatic logic is_unc(input logic [31:0] pc);
        return pc[31:29] == 3'b101;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        mem_addr_ok = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rlast   = 1'b0;
    endtask

    // Serves one request seen at a negedge; returns early if reset is observed.
    task automatic serve();
        logic [31:0] a;
        logic [1:0]  l;
        int w;
        int g;
        int st;
        a = mem_raddr;
        l = mem_rlen;
        n_req++;
        last_raddr = a;
        last_rlen  = l;
        chk("req_addr", a, exp_raddr);
        chk("req_len", {30'd0, l}, {30'd0, exp_rlen});
        w  = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 2));
        st = 2 + w;
        last_exp_stall = st;
        for (int i = 0; i < w; i++) begin
            mem_rvalid = spurious_en && ($urandom_range(0, 2) == 0);
            mem_rlast  = mem_rvalid;
            mem_rdata  = $urandom;
            @(negedge clk);
            if (rst) begin bus_idle(); return; end
            chk1("req_hold_rreq", mem_rreq, 1'b1);
            chk("req_hold_addr", mem_raddr, a);
            chk("req_hold_len", {30'd0, mem_rlen}, {30'd0, l});
        end
        mem_rvalid  = 1'b0;
        mem_rlast   = 1'b0;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        mem_addr_ok = 1'b0;
        if (rst) begin bus_idle(); return; end
        chk1("rreq_drop", mem_rreq, 1'b0);
        for (int b = 0; b <= int'(l); b++) begin
            g  = (force_gap >= 0) ? force_gap : int'($urandom_range(0, max_gap));
            st = st + g + 1;
            last_exp_stall = st;
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                if (rst) begin bus_idle(); return; end
            end
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(a + 32'(4 * b));
            mem_rlast  = (b == int'(l));
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rlast  = 1'b0;
            if (rst) begin bus_idle(); return; end
            beats_done++;
        end
    endtask

    initial begin
        mem_rdata = '0;
        bus_idle();
        forever begin
            @(negedge clk);
            if (!rst && mem_rreq) serve();
        end
    end

    // Per-cycle compare: a completed fetch always shows the memory word at its physical address.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (inst_enF && !i_cache_stall) begin
                chk("mon_instr", instrF, mem_word(paddr_of(pcF)));
                chk1("mon_hit", i_cache_hit, !is_unc(pcF));
            end
            if (expect_idle) begin
                chk1("idle_stall", i_cache_stall, 1'b0);
                chk("idle_instr", instrF, 32'h0);
                chk1("idle_hit", i_cache_hit, 1'b0);
            end
        end
    end

    task automatic fetch(input logic [31:0] pc, input int hold);
        logic [31:0] pa;
        logic        unc;
        logic [5:0]  idx;
        logic [21:0] tg;
        logic        exp_hit;
        int          req0;
        int          cyc;
        pa      = paddr_of(pc);
        unc     = is_unc(pc);
        idx     = pa[9:4];
        tg      = pa[31:10];
        exp_hit = !unc && mvalid[idx] && (mtag[idx] == tg);
        exp_raddr = unc ? pa : {pa[31:4], 4'h0};
        exp_rlen  = unc ? 2'd0 : 2'd3;
        req0 = n_req;
        @(posedge clk);
        #1;
        expect_idle = 1'b0;
        pcF      = pc;
        inst_enF = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (i_cache_stall && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        if (i_cache_stall) begin
            chk1("fetch_timeout", i_cache_stall, 1'b0);
            return;
        end
        chk("fetch_instr", instrF, mem_word(pa));
        chk1("fetch_hit", i_cache_hit, !unc);
        chk("fetch_nreq", n_req - req0, exp_hit ? 0 : 1);
        chk("fetch_lat", cyc, exp_hit ? 0 : last_exp_stall);
        $display("fetch pc=%h instr=%h stall_cycles=%0d model_hit=%0d", pc, instrF, cyc, exp_hit);
        if (!unc) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
        end
        if (hold > 0) begin
            #1 cpu_stall = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                chk("hold_instr", instrF, mem_word(pa));
                chk1("hold_stall", i_cache_stall, 1'b0);
            end
            #1 cpu_stall = 1'b0;
        end
    endtask

    task automatic wait_beats(input int k);
        int c = 0;
        while (beats_done < k && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk1("beats_timeout", beats_done >= k, 1'b1);
    endtask

    task automatic wait_stall_low();
        int c = 0;
        while (i_cache_stall && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk1("stall_timeout", i_cache_stall, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_rreq"}, mem_rreq, 1'b0);
        chk({tag, "_raddr"}, mem_raddr, 32'h0);
        chk({tag, "_rlen"}, {30'd0, mem_rlen}, 32'h0);
        chk({tag, "_instr"}, instrF, 32'h0);
        chk1({tag, "_hit"}, i_cache_hit, 1'b0);
        chk1({tag, "_stall"}, i_cache_stall, 1'b0);
    endtask

    initial begin
        int          n;
        int          c;
        int          sel;
        logic [2:0]  sg;
        logic [28:0] pa29;
        rst = 1'b1;
        pcF = '0;
        inst_enF = 1'b0;
        cpu_stall = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = '0;
        end
        @(negedge clk);
        check_reset_outputs("rst_hold");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_out");
        mon_en = 1'b1;
        expect_idle = 1'b1;
        repeat (2) @(negedge clk);

        // Boot-vector uncached fetch, then a repeat that must re-request.
        fetch(32'hBFC00000, 0);
        chk("t1_raddr", last_raddr, 32'h1FC00000);
        chk("t1_rlen", {30'd0, last_rlen}, 32'h0);
        chk("t1_instr", instrF, 32'h3C080001);
        chk1("t1_hit", i_cache_hit, 1'b0);
        n = n_req;
        fetch(32'hBFC00000, 0);
        chk("t1_refetch", n_req - n, 1);

        // Cold line fill, then a neighbouring word hits with no request.
        fetch(32'h80000014, 0);
        chk("t2_raddr", last_raddr, 32'h00000010);
        chk("t2_rlen", {30'd0, last_rlen}, 32'h3);
        chk("t2_instr", instrF, mem_word(32'h00000014));
        n = n_req;
        fetch(32'h80000018, 0);
        chk("t2_nextword_nreq", n_req - n, 0);

        // Same index, different tag evicts.
        fetch(32'h80000000, 0);
        fetch(32'h80000400, 0);
        n = n_req;
        fetch(32'h80000000, 0);
        chk("t3_conflict_nreq", n_req - n, 1);

        // Slow bridge: accept after 3 cycles and gapped beats.
        force_wait = 3;
        force_gap  = 2;
        fetch(32'h80000120, 0);
        fetch(32'hBFC00040, 0);
        force_wait = -1;
        force_gap  = -1;

        // Flush mid-refill: the line still installs, new pcF looked up afterwards.
        exp_raddr = 32'h00000230;
        exp_rlen  = 2'd3;
        beats_done = 0;
        n = n_req;
        @(posedge clk);
        #1 expect_idle = 1'b0;
        pcF = 32'h80000230;
        inst_enF = 1'b1;
        wait_beats(1);
        #1 inst_enF = 1'b0;
        pcF = 32'h80000674;
        wait_stall_low();
        chk("t5_flush_nreq", n_req - n, 1);
        mvalid[6'h23] = 1'b1;
        mtag[6'h23]   = 22'h0;
        fetch(32'h80000230, 0);
        fetch(32'h80000674, 0);

        // Flush mid-uncached: data discarded, next fetch re-requests.
        exp_raddr = 32'h1FC00100;
        exp_rlen  = 2'd0;
        n = n_req;
        @(posedge clk);
        #1 pcF = 32'hBFC00100;
        inst_enF = 1'b1;
        c = 0;
        while (n_req == n && c < 100) begin
            @(negedge clk);
            c++;
        end
        #1 inst_enF = 1'b0;
        pcF = 32'h80000000;
        wait_stall_low();
        fetch(32'hBFC00100, 0);

        // Reset during refill after two beats.
        force_gap = 3;
        exp_raddr = 32'h00000340;
        exp_rlen  = 2'd3;
        beats_done = 0;
        n = n_req;
        @(posedge clk);
        #1 pcF = 32'h80000340;
        inst_enF = 1'b1;
        wait_beats(2);
        @(posedge clk);
        #2 rst = 1'b1;
        inst_enF = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        @(posedge clk);
        #2 rst = 1'b0;
        force_gap = -1;
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        chk("t6_req_before", n_req - n, 1);
        expect_idle = 1'b1;
        @(negedge clk);
        n = n_req;
        fetch(32'h80000340, 0);
        chk("t6_reissue", n_req - n, 1);
        fetch(32'h80000014, 0);

        // cpu_stall held across UC_DONE keeps the word stable.
        fetch(32'hBFC00010, 4);

        // Random fetch stream over a small address pool to mix hits, conflicts and bypasses.
        max_gap = 2;
        for (int i = 0; i < 400; i++) begin
            sel  = int'($urandom_range(0, 7));
            sg   = (sel == 0) ? 3'b101 : ((sel < 3) ? 3'b000 : 3'b100);
            pa29 = {19'($urandom_range(0, 2)), 6'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 2'b00};
            fetch({sg, pa29}, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1 inst_enF = 1'b0;
                expect_idle = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk);
            end
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/i_cache.md
Name: i_cache

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the pipeline IF stage.
- Consumes the fetch PC and fetch enable from the datapath.
- Returns the instruction word, a stall flag and a hit flag that the hazard unit and IF/ID register consume.
- On a miss it refills a full line through a burst read port to the memory bridge; kseg1 fetches bypass the cache as single-word reads.

Parameters:
INDEX_WIDTH, 6, log2 of line count (64 lines)
OFFSET_WIDTH, 4, log2 of line bytes (16 B = 4 words); TAG_WIDTH = 32-INDEX_WIDTH-OFFSET_WIDTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
pcF  in  32  fetch virtual address, word aligned when inst_enF=1
inst_enF  in  1  fetch request this cycle
cpu_stall  in  1  pipeline stalled for any other reason; fetch result must be held
instrF  out  32  instruction for pcF, valid when inst_enF & ~i_cache_stall
i_cache_stall  out  1  fetch not complete; freeze F/D
i_cache_hit  out  1  pulse: cached lookup hit this cycle
mem_rreq  out  1  burst read request, held until accepted
mem_raddr  out  32  physical start address
mem_rlen  out  2  beats-1 (3 for line refill, 0 for uncached)
mem_addr_ok  in  1  request accepted this cycle
mem_rvalid  in  1  read beat valid
mem_rdata  in  32  read beat data
mem_rlast  in  1  final beat

Behaviour:
- Physical address: paddr = {3'b000, pcF[28:0]}. Uncached when pcF[31:29]==3'b101.
- Address split: tag = paddr[31:INDEX_WIDTH+OFFSET_WIDTH], index = next INDEX_WIDTH bits, word = paddr[OFFSET_WIDTH-1:2].
- Arrays are flops: valid[], tag[], data[][]. Lookup is combinational on pcF.
- hit = cached & valid[index] & tag match.
- States:
  - IDLE:
    - inst_enF=0 -> stall 0, instrF 0.
    - cached hit -> instrF = data word, stall 0, i_cache_hit 1, stay IDLE.
    - cached miss -> stall 1, go MISS_REQ.
    - uncached -> stall 1, go UC_REQ.
  - MISS_REQ: mem_rreq=1, mem_raddr = paddr with low OFFSET_WIDTH bits zero, mem_rlen=3. On mem_addr_ok -> REFILL; beat counter = 0.
  - REFILL:
    - Each mem_rvalid writes mem_rdata into data[index][counter], then counter+1 (wraps at 4).
    - valid[index] is cleared on REFILL entry.
    - On mem_rvalid & mem_rlast: set valid[index], write tag, go IDLE.
    - Re-lookup in the next cycle hits. Miss-to-result latency = 1 + accept wait + beats + 1.
  - UC_REQ: mem_rreq=1, mem_raddr = paddr, mem_rlen=0. On mem_addr_ok -> UC_WAIT.
  - UC_WAIT: on mem_rvalid, latch mem_rdata into uc_buf -> UC_DONE. No array write.
  - UC_DONE: instrF = uc_buf, stall 0. Leave to IDLE in the first cycle with cpu_stall=0; otherwise hold uc_buf.
- Stall output: i_cache_stall = 1 in MISS_REQ, REFILL, UC_REQ, UC_WAIT, and in IDLE on a cached miss or uncached request with inst_enF=1; 0 otherwise.
- Request signals: mem_rreq, mem_raddr and mem_rlen stay stable from assertion until the mem_addr_ok cycle; mem_rreq drops the cycle after acceptance.
- Index/tag capture: the miss index and tag are registered when leaving IDLE. pcF changes during a miss must not corrupt the refill.
- Mid-transaction abort: inst_enF falling (exception flush) mid-miss or mid-uncached never aborts. The burst completes and the line is still installed; uncached data is discarded (UC_DONE -> IDLE if inst_enF=0).
- mem_rvalid outside REFILL/UC_WAIT is ignored.
- Reset (asynchronous, any state including mid-refill):
  - state IDLE, all valid bits 0, counter 0, uc_buf 0.
  - Outputs after reset: mem_rreq 0, mem_raddr 0, mem_rlen 0, instrF 0, i_cache_hit 0; i_cache_stall 0 while inst_enF=0.
  - Tag/data contents are don't-care.

Test Plan:
- Reset, inst_enF=1, pcF=0xBFC00000 -> UC_REQ with mem_raddr=0x1FC00000, mem_rlen=0. Return 0x3C080001 -> stall drops one cycle later, instrF=0x3C080001, i_cache_hit=0; repeating the fetch re-requests (no allocation).
- pcF=0x80000014 cold -> mem_raddr=0x00000010, rlen=3. Beats A0..A3 -> cycle after rlast: instrF=A1, hit=1, stall=0. Then pcF=0x80000018 -> A2 with zero stall.
- Conflict: fill 0x80000000, then fetch 0x80000400 (same index, different tag) -> miss and refill. Return to 0x80000000 -> miss again.
- Insert 3 wait cycles before mem_addr_ok, and gaps between beats -> request fields stay constant, data lands in order, no early stall release.
- Drop inst_enF and change pcF during REFILL -> burst completes, the original line becomes valid, the new pcF is looked up afterwards.
- Assert rst in REFILL after 2 beats -> next fetch of the same line misses, mem_rreq re-issues; cpu_stall=1 in UC_DONE holds instrF for the full stall.
